trap_ctrl: RTL and testbench

- Trap sequencer that sits directly upstream of the machine-mode CSR register file.
- Watches the instruction in the MEM stage for exceptions, MRET and the external interrupt.
- Produces the trap/mret pulses and the mepc/mcause/mtval values the CSR file latches, then redirects fetch to mtvec or mepc.
- Stalls the pipeline while a trap or return is being sequenced.

---
 rtl/trap_ctrl.sv | 139 +++++++++++++
 tb/tb_trap_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences traps and MRET into the CSR file and redirects fetch.
// Optional TRAP_VECTORED_EN: sends interrupts to mtvec base + 4*cause when mtvec is in vectored mode.
module trap_ctrl #(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic            mem_stall,
    input  logic [XLEN-1:0] pc_mem,
    input  logic [XLEN-1:0] mem_addr,
    input  logic            illegal_inst,
    input  logic            ecall,
    input  logic            ebreak,
    input  logic            l_misalign,
    input  logic            l_fault,
    input  logic            s_misalign,
    input  logic            s_fault,
    input  logic            mret_mem,
    input  logic            ext_int,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            trap,
    output logic            mret,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mtval_o,
    output logic            kill_mem,
    output logic            stall_req,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);
    typedef enum logic [1:0] {IDLE, TRAP, RET, REDIR} state_t;

    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [XLEN-1:0]        r_epc, r_cause, r_tval, r_hcause, r_htval;
    logic                   r_int, r_ret;
    logic                   w_irq, w_exc, w_det, w_ret, w_unused;
    logic [XLEN-1:0]        w_cause, w_tval, w_base, w_vec;

    assign w_irq = r_sync[SYNC_STAGES-1] & mstatus[3];
    assign w_exc = illegal_inst | ecall | ebreak | l_misalign | l_fault | s_misalign | s_fault;
    assign w_det = (r_state == IDLE) & mem_valid & ~mem_stall & ~rst & (w_irq | w_exc | mret_mem);
    assign w_ret = ~w_irq & ~w_exc;

    assign w_cause = w_irq        ? {1'b1, (XLEN-1)'(11)} :
                     illegal_inst ? XLEN'(2)  :
                     ecall        ? XLEN'(11) :
                     ebreak       ? XLEN'(3)  :
                     l_misalign   ? XLEN'(4)  :
                     l_fault      ? XLEN'(5)  :
                     s_misalign   ? XLEN'(6)  : XLEN'(7);
    assign w_tval  = (w_irq | illegal_inst | ecall) ? '0 : ebreak ? pc_mem : mem_addr;

    assign w_base = {mtvec[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    assign w_vec = (r_int && mtvec[1:0] == 2'b01) ? {r_cause[XLEN-3:0], 2'b00} : '0;
`else
    assign w_vec = '0;
`endif
    assign w_unused = &{1'b0, mstatus[XLEN-1:4], mstatus[2:0], mtvec[1:0], r_cause[XLEN-1:XLEN-2]};

    // ext_int synchroniser; the level is sampled, never latched
    always_ff @(posedge clk or posedge rst)
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], ext_int};

    // state register plus trap context captured at detect and committed in TRAP
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state  <= IDLE;
            r_epc    <= '0;
            r_cause  <= '0;
            r_tval   <= '0;
            r_int    <= 1'b0;
            r_ret    <= 1'b0;
            r_hcause <= '0;
            r_htval  <= '0;
        end else begin
            r_state <= w_next;
            if (w_det) begin
                r_epc   <= pc_mem;
                r_cause <= w_cause;
                r_tval  <= w_tval;
                r_int   <= w_irq;
                r_ret   <= w_ret;
            end
            if (r_state == TRAP) begin
                r_hcause <= r_cause;
                r_htval  <= r_tval;
            end
        end

    // next state and per-state outputs
    always_comb begin
        w_next      = r_state;
        trap        = 1'b0;
        mret        = 1'b0;
        mepc_o      = '0;
        mcause_o    = '0;
        mtval_o     = '0;
        kill_mem    = 1'b0;
        stall_req   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        case (r_state)
            IDLE: begin
                kill_mem  = w_det;
                stall_req = w_det;
                w_next    = w_det ? (w_ret ? RET : TRAP) : IDLE;
            end
            TRAP: begin
                trap      = 1'b1;
                stall_req = 1'b1;
                mepc_o    = r_epc;
                mcause_o  = r_cause;
                mtval_o   = r_tval;
                w_next    = REDIR;
            end
            RET: begin
                mret      = 1'b1;
                stall_req = 1'b1;
                mepc_o    = mepc;
                mcause_o  = r_hcause;
                mtval_o   = r_htval;
                w_next    = REDIR;
            end
            default: begin
                redirect    = 1'b1;
                stall_req   = 1'b1;
                redirect_pc = r_ret ? mepc : w_base + w_vec;
                w_next      = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed checks of trap_ctrl sequencing, priority, interrupt sync and reset abort.
module tb_trap_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_valid = 0, mem_stall = 0;
    logic [31:0] pc_mem = 0, mem_addr = 0;
    logic        illegal_inst = 0, ecall = 0, ebreak = 0;
    logic        l_misalign = 0, l_fault = 0, s_misalign = 0, s_fault = 0;
    logic        mret_mem = 0, ext_int = 0;
    logic [31:0] mstatus = 0, mtvec = 32'h200, mepc = 0;
    logic        trap, mret, kill_mem, stall_req, redirect;
    logic [31:0] mepc_o, mcause_o, mtval_o, redirect_pc;
    int          n_checks = 0, n_errors = 0;

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] IRQ_PC = 32'h22C;
`else
    localparam logic [31:0] IRQ_PC = 32'h200;
`endif

    trap_ctrl dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_stall(mem_stall),
        .pc_mem(pc_mem), .mem_addr(mem_addr), .illegal_inst(illegal_inst),
        .ecall(ecall), .ebreak(ebreak), .l_misalign(l_misalign), .l_fault(l_fault),
        .s_misalign(s_misalign), .s_fault(s_fault), .mret_mem(mret_mem),
        .ext_int(ext_int), .mstatus(mstatus), .mtvec(mtvec), .mepc(mepc),
        .trap(trap), .mret(mret), .mepc_o(mepc_o), .mcause_o(mcause_o),
        .mtval_o(mtval_o), .kill_mem(kill_mem), .stall_req(stall_req),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic clear_ev;
        mem_valid = 0; illegal_inst = 0; ecall = 0; ebreak = 0; l_misalign = 0;
        l_fault = 0; s_misalign = 0; s_fault = 0; mret_mem = 0;
    endtask

    // present one event at pc for the detect cycle, then walk TRAP and REDIR
    task automatic run_trap(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                            input logic [31:0] tval, input logic [31:0] rpc);
        mem_valid = 1; pc_mem = pc;
        settle;
        check({tag, " kill"}, {31'b0, kill_mem}, 1);
        check({tag, " stall0"}, {31'b0, stall_req}, 1);
        tick; clear_ev; settle;
        check({tag, " trap"}, {31'b0, trap}, 1);
        check({tag, " mepc"}, mepc_o, pc);
        check({tag, " mcause"}, mcause_o, cause);
        check({tag, " mtval"}, mtval_o, tval);
        check({tag, " nomret"}, {31'b0, mret}, 0);
        tick; settle;
        check({tag, " redir"}, {31'b0, redirect}, 1);
        check({tag, " rpc"}, redirect_pc, rpc);
        check({tag, " trap1"}, {31'b0, trap}, 0);
        check({tag, " mepc0"}, mepc_o, 0);
        tick; settle;
        check({tag, " idle"}, {30'b0, stall_req, redirect}, 0);
    endtask

    initial begin
        tick; tick; settle;
        check("rst outs", {trap, mret, kill_mem, stall_req, redirect}, 0);
        check("rst mcause", mcause_o, 0);
        rst = 0; tick;
        illegal_inst = 1; l_misalign = 1; mem_addr = 32'h1003;
        run_trap("illegal", 32'h40, 2, 0, 32'h200);
        ebreak = 1;
        run_trap("ebreak", 32'h80, 3, 32'h80, 32'h200);
        l_fault = 1; mret_mem = 1; mem_addr = 32'h2000;
        run_trap("lfault+mret", 32'h90, 5, 32'h2000, 32'h200);
        s_misalign = 1; mem_addr = 32'h3002;
        run_trap("smis", 32'ha0, 6, 32'h3002, 32'h200);
        ecall = 1;
        run_trap("ecall", 32'h100, 11, 0, 32'h200);
        // mret with held mcause=11
        mepc = 32'h104; mret_mem = 1; mem_valid = 1; pc_mem = 32'h120;
        settle;
        check("mret kill", {31'b0, kill_mem}, 1);
        tick; clear_ev; settle;
        check("mret pulse", {31'b0, mret}, 1);
        check("mret notrap", {31'b0, trap}, 0);
        check("mret mepc", mepc_o, 32'h104);
        check("mret mcause", mcause_o, 11);
        check("mret mtval", mtval_o, 0);
        tick; settle;
        check("mret redir", {31'b0, redirect}, 1);
        check("mret rpc", redirect_pc, 32'h104);
        tick; settle;
        // stalled MEM stage ignores events
        ecall = 1; mem_valid = 1; mem_stall = 1;
        settle;
        check("stall kill", {31'b0, kill_mem}, 0);
        tick; settle;
        check("stall notrap", {31'b0, trap}, 0);
        clear_ev; mem_stall = 0;
        // interrupt with MIE=0 is never taken
        mstatus = 32'h80; ext_int = 1; mem_valid = 1; pc_mem = 32'h300;
        for (int i = 0; i < 4; i++) begin
            settle;
            check("mie0 kill", {31'b0, kill_mem}, 0);
            tick;
        end
        ext_int = 0; mem_valid = 0;
        tick; tick; tick;
        // interrupt with MIE=1 appears after SYNC_STAGES edges
        mstatus = 32'h88; mtvec = 32'h201; ext_int = 1; mem_valid = 1; pc_mem = 32'h300;
        settle;
        check("irq sync0", {31'b0, kill_mem}, 0);
        tick; settle;
        check("irq sync1", {31'b0, kill_mem}, 0);
        tick;
        run_trap("irq", 32'h300, 32'h8000000B, 0, IRQ_PC);
        ext_int = 0; mstatus = 0;
        tick; tick; tick;
        ecall = 1;
        run_trap("vec ecall", 32'h140, 11, 0, 32'h200);
        mtvec = 32'h200;
        // reset during TRAP cycle aborts the sequence
        ecall = 1; mem_valid = 1; pc_mem = 32'h180;
        tick; clear_ev; rst = 1; settle;
        check("abort outs", {trap, mret, kill_mem, stall_req, redirect}, 0);
        check("abort mepc", mepc_o, 0);
        tick; rst = 0;
        for (int i = 0; i < 2; i++) begin
            settle;
            check("abort noredir", {30'b0, redirect, trap}, 0);
            tick;
        end
        ecall = 1;
        run_trap("post rst", 32'h1c0, 11, 0, 32'h200);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
